datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Initiator side of the datapath control interface. It accepts 16-bit instructions over a valid/ready handshake and drives the datapath's Opcode, RegEnable and Cin inputs. It captures the datapath's AluBus and Flags, holds the processor status flags, and reports retired results upstream. It sits between instruction fetch and the datapath, and is the only block that asserts RegEnable.

Parameters:
CMP_OP, 8'h0B, ALU op code {Instr[15:12],Instr[7:4]} that updates flags only; no register write.
CARRY_BIT, 0, index within Flags of the carry flag fed back as Cin.
COUNT_W, 16, width of the retired-instruction counter.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset.
InstrValid  input  1  Instr is valid this cycle.
Instr  input  16  [15:12],[7:4] = ALU op; [11:8] = Rdest/RsrcA; [3:0] = RsrcB.
InstrReady  output  1  sequencer can accept Instr this cycle.
Opcode  output  16  registered copy of the accepted Instr, to the datapath.
RegEnable  output  16  one-hot register write enable, to the datapath.
Cin  output  1  carry-in to the ALU, equal to StatusFlags[CARRY_BIT].
Flags  input  5  flags from the datapath ALU.
AluBus  input  16  ALU result from the datapath.
Result  output  16  AluBus captured at retirement.
StatusFlags  output  5  flags captured at retirement.
Done  output  1  one-cycle pulse: instruction retired.
RetireCount  output  COUNT_W  number of instructions retired; wraps.

Behaviour:
- Reset asserted (Reset=0), asynchronously: state=IDLE, Opcode=0, RegEnable=0, Result=0, StatusFlags=0, Cin=0, Done=0, RetireCount=0. RegEnable drops immediately, so no register write happens during reset.
- All outputs are registered except InstrReady, which decodes the state. InstrReady=1 in IDLE and DONE, 0 in EXEC.
- Accept: InstrValid && InstrReady at a rising edge.
  - Opcode <= Instr.
  - RegEnable <= one-hot(Instr[11:8]), or 16'h0000 if {Instr[15:12],Instr[7:4]}==CMP_OP.
  - state <= EXEC.
- EXEC (exactly one cycle):
  - Opcode stable; the datapath reads both operands and the ALU settles combinationally.
  - The register file writes AluBus at the closing edge of EXEC.
  - At that edge: Result <= AluBus, StatusFlags <= Flags, RegEnable <= 0, RetireCount += 1 (wraps to 0 past all ones), Done <= 1, state <= DONE.
- DONE (one cycle): Done=1; Result and StatusFlags valid.
  - On accept → EXEC (back-to-back).
  - Otherwise → IDLE, Done <= 0.
- IDLE: Done=0; Opcode and Result hold their last values; on accept → EXEC.
- Throughput: one instruction per 2 cycles when back-to-back. Latency from accept edge to Done high: 2 edges.
- RegEnable has at most one bit set and is nonzero only during EXEC.
- Cin is taken from StatusFlags, so an instruction sees the carry of the previously retired instruction, including across back-to-back issue.
- StatusFlags change only at retirement. CMP_OP updates StatusFlags and Result but writes no register.
- InstrValid while InstrReady=0 is ignored. Instr is not captured and the upstream must hold it.
- Reset mid-EXEC aborts the instruction: no write, no Done, RetireCount stays 0.

Test Plan:
Bench uses a behavioural datapath model with preloadable registers and CR16 op codes.
1. Reset, then idle 5 cycles → InstrReady=1, RegEnable=0, Done=0, RetireCount=0.
2. r2=16'h0003, r5=16'h0004; issue ADD Instr=16'h0255 → RegEnable=16'h0004 for one cycle; Done next cycle; Result=16'h0007; r2=7; RetireCount=1.
3. r1=16'hFFFF, r3=16'h0001; issue ADD Instr=16'h0153, then ADDC Instr=16'h0473 back-to-back →
   - first: Result=0, StatusFlags[CARRY_BIT]=1;
   - second: Cin=1, r4 gains +1;
   - two Done pulses 2 cycles apart.
4. Issue CMP Instr=16'h02B5 → RegEnable stays 16'h0000 all cycles; StatusFlags updated; register contents unchanged.
5. Hold InstrValid during EXEC with a different Instr → not accepted until DONE; Opcode unchanged during EXEC.
6. Drop Reset to 0 mid-EXEC → RegEnable=0 immediately; the destination register is unchanged; after release, state=IDLE and RetireCount=0.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the datapath: accepts one instruction at a time, drives
// Opcode/RegEnable/Cin, then retires AluBus and Flags into Result/StatusFlags.
module datapath_sequencer #(
  parameter logic [7:0] CMP_OP    = 8'h0B,
  parameter int         CARRY_BIT = 0,
  parameter int         COUNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               InstrValid,
  input  logic [15:0]        Instr,
  output logic               InstrReady,
  output logic [15:0]        Opcode,
  output logic [15:0]        RegEnable,
  output logic               Cin,
  input  logic [4:0]         Flags,
  input  logic [15:0]        AluBus,
  output logic [15:0]        Result,
  output logic [4:0]         StatusFlags,
  output logic               Done,
  output logic [COUNT_W-1:0] RetireCount
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        opcode_q, opcode_d;
  logic [15:0]        reg_en_q, reg_en_d;
  logic [15:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic       accept;
  logic [7:0] alu_op;

  assign InstrReady = (state_q != ST_EXEC);
  assign accept     = InstrValid && InstrReady;
  assign alu_op     = {Instr[15:12], Instr[7:4]};

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    state_d  = state_q;
    opcode_d = opcode_q;
    reg_en_d = reg_en_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_EXEC;
          opcode_d = Instr;
          reg_en_d = (alu_op == CMP_OP) ? 16'h0000 : (16'h0001 << Instr[11:8]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The register file writes AluBus on this same edge, so capture it alongside.
        state_d  = ST_DONE;
        result_d = AluBus;
        flags_d  = Flags;
        reg_en_d = 16'h0000;
        count_d  = count_q + COUNT_W'(1);
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      reg_en_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      reg_en_q <= reg_en_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign Opcode      = opcode_q;
  assign RegEnable   = reg_en_q;
  assign Result      = result_q;
  assign StatusFlags = flags_q;
  assign Cin         = flags_q[CARRY_BIT];
  assign Done        = done_q;
  assign RetireCount = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: behavioural datapath with preloadable registers,
// reference model computing expected retirements, and a scoreboard monitor.
module tb_datapath_sequencer;

  localparam logic [7:0] CMP_OP = 8'h0B;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [15:0] Opcode;
  logic [15:0] RegEnable;
  logic        Cin;
  logic [4:0]  Flags;
  logic [15:0] AluBus;
  logic [15:0] Result;
  logic [4:0]  StatusFlags;
  logic        Done;
  logic [15:0] RetireCount;

  always #5 Clk = ~Clk;

  datapath_sequencer #(.CMP_OP(CMP_OP), .CARRY_BIT(0), .COUNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .Instr(Instr),
    .InstrReady(InstrReady), .Opcode(Opcode), .RegEnable(RegEnable), .Cin(Cin),
    .Flags(Flags), .AluBus(AluBus), .Result(Result), .StatusFlags(StatusFlags),
    .Done(Done), .RetireCount(RetireCount)
  );

  // Flags layout: [0]=C, [1]=L, [2]=F (overflow), [3]=N, [4]=Z.
  function automatic logic [20:0] alu(input logic [7:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    f = '0;
    r = a;
    s = '0;
    case (op)
      8'h05: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; f[0] = s[16]; f[2] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      8'h07: begin
        s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        r = s[15:0]; f[0] = s[16]; f[2] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      8'h09: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0]; f[0] = s[16]; f[2] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      8'h01: begin r = a & b; f[0] = cin; end
      8'h02: begin r = a | b; f[0] = cin; end
      8'h03: begin r = a ^ b; f[0] = cin; end
      8'h0D: begin r = b;     f[0] = cin; end
      8'h0B: begin
        r = a - b; f[0] = cin; f[1] = (a < b);
        f[3] = ($signed(a) < $signed(b)); f[4] = (a == b);
        return {f, r};
      end
      default: begin r = a; f[0] = cin; end
    endcase
    f[3] = r[15];
    f[4] = (r == 16'h0000);
    return {f, r};
  endfunction

  // Behavioural datapath: registers written only through RegEnable or the preload port.
  logic [15:0] dp_regs [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;
  logic [20:0] dp_out;

  always_comb begin
    dp_out = alu({Opcode[15:12], Opcode[7:4]}, dp_regs[Opcode[11:8]], dp_regs[Opcode[3:0]], Cin);
    AluBus = dp_out[15:0];
    Flags  = dp_out[20:16];
  end

  always @(posedge Clk) begin
    for (int i = 0; i < 16; i++) if (RegEnable[i]) dp_regs[i] <= AluBus;
    if (pl_en) dp_regs[pl_idx] <= pl_val;
  end

  typedef struct {
    logic [15:0] result;
    logic [4:0]  flags;
    logic [15:0] count;
    logic [3:0]  rd;
    logic [15:0] rd_val;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] ref_regs [16];
  logic [4:0]  ref_flags = '0;
  logic [15:0] ref_count = '0;
  logic [15:0] last_op   = '0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          neg_cnt   = 0;
  int          done_log[$];
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    @(negedge Clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge Clk);
    pl_en = 1'b0;
    ref_regs[idx] = val;
  endtask

  // Offers instr until accepted; with exec_chk, returns at the EXEC negedge after checking it.
  task automatic issue(input logic [15:0] instr, input bit expect_it, input bit exec_chk);
    bit          acc;
    int          waited;
    logic [7:0]  op;
    logic [3:0]  rd, rb;
    logic [20:0] o;
    logic [15:0] exp_re;
    logic        exp_cin;
    acc = 0; waited = 0;
    while (!acc && waited < 20) begin
      @(negedge Clk);
      InstrValid = 1'b1; Instr = instr;
      check("opcode_stable", Opcode, last_op);
      if (InstrReady) acc = 1; else waited++;
    end
    if (!acc) begin
      fail_now("issue_timeout");
      InstrValid = 1'b0;
      return;
    end
    @(posedge Clk);
    op = {instr[15:12], instr[7:4]};
    rd = instr[11:8];
    rb = instr[3:0];
    exp_cin = ref_flags[0];
    o = alu(op, ref_regs[rd], ref_regs[rb], exp_cin);
    exp_re = (op == CMP_OP) ? 16'h0000 : (16'h0001 << rd);
    if (expect_it) begin
      if (op != CMP_OP) ref_regs[rd] = o[15:0];
      ref_flags = o[20:16];
      ref_count = ref_count + 16'd1;
      sb_q.push_back('{result: o[15:0], flags: o[20:16], count: ref_count,
                       rd: rd, rd_val: ref_regs[rd]});
    end
    last_op = instr;
    #1;
    InstrValid = 1'b0;
    check("exec_regen", RegEnable, exp_re);
    if (exec_chk) begin
      @(negedge Clk);
      check("exec_ready", InstrReady, 1'b0);
      check("exec_opcode", Opcode, instr);
      check("exec_cin", Cin, exp_cin);
      check("exec_done", Done, 1'b0);
    end
  endtask

  always @(negedge Clk) begin
    neg_cnt++;
    if (Reset === 1'b1) begin
      check("regen_onehot", $countones(RegEnable) <= 1, 1);
      if (InstrReady) check("regen_idle_zero", RegEnable, 16'h0000);
      if (Done) begin
        done_log.push_back(neg_cnt);
        check("done_pulse", prev_done, 1'b0);
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got Done=1 expected no retirement");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", Result, e.result);
          check("status_flags", StatusFlags, e.flags);
          check("retire_count", RetireCount, e.count);
          check("dest_reg", dp_regs[e.rd], e.rd_val);
          check("cin_follows_carry", Cin, e.flags[0]);
        end
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [7:0]  ops [8];
    logic [15:0] r4_before;
    ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D};
    Reset = 1'b0; InstrValid = 1'b0; Instr = '0;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
    @(negedge Clk);
    Reset = 1'b1;

    // Reset state and idle
    repeat (5) @(negedge Clk);
    check("t1_ready", InstrReady, 1'b1);
    check("t1_regen", RegEnable, 16'h0000);
    check("t1_done", Done, 1'b0);
    check("t1_count", RetireCount, 16'h0000);
    check("t1_status", {Cin, StatusFlags, Result, Opcode}, '0);

    // Single ADD
    preload(4'd2, 16'h0003);
    preload(4'd5, 16'h0004);
    issue(16'h0255, 1, 1);
    @(negedge Clk); #1;
    check("t2_result", Result, 16'h0007);
    check("t2_r2", dp_regs[2], 16'h0007);
    check("t2_count", RetireCount, 16'h0001);
    check("t2_regen_after", RegEnable, 16'h0000);

    // Carry out of ADD feeds ADDC issued back-to-back
    preload(4'd1, 16'hFFFF);
    preload(4'd3, 16'h0001);
    preload(4'd4, 16'h0010);
    r4_before = 16'h0010;
    issue(16'h0153, 1, 1);
    issue(16'h0473, 1, 1);
    check("t3_first_result", Result, 16'h0000);
    check("t3_first_carry", StatusFlags[0], 1'b1);
    check("t3_cin", Cin, 1'b1);
    @(negedge Clk); #1;
    check("t3_addc_carry", dp_regs[4], r4_before + 16'h0001 + 16'h0001);
    if (done_log.size() >= 2) check("t3_done_gap", done_log[$] - done_log[$-1], 2);
    else fail_now("t3_done_gap");

    // CMP: flags only, no register write
    issue(16'h02B5, 1, 1);
    @(negedge Clk); #1;
    check("t4_r2_kept", dp_regs[2], ref_regs[2]);
    check("t4_r5_kept", dp_regs[5], ref_regs[5]);
    check("t4_flags", StatusFlags, ref_flags);

    // InstrValid held during EXEC with a different instruction
    issue(16'h0355, 1, 1);
    InstrValid = 1'b1; Instr = 16'h0691;
    issue(16'h0691, 1, 1);
    repeat (2) @(negedge Clk);

    // Reset in the middle of EXEC aborts the instruction
    preload(4'd7, 16'h1234);
    preload(4'd8, 16'h0101);
    issue(16'h0758, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    check("t6_regen_drop", RegEnable, 16'h0000);
    @(negedge Clk);
    check("t6_r7_kept", dp_regs[7], 16'h1234);
    check("t6_no_done", Done, 1'b0);
    Reset = 1'b1;
    ref_flags = '0; ref_count = '0; last_op = '0;
    @(negedge Clk); #1;
    check("t6_ready", InstrReady, 1'b1);
    check("t6_count", RetireCount, 16'h0000);
    check("t6_opcode", Opcode, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 7)];
      issue({op[7:4], 4'($urandom), op[3:0], 4'($urandom)}, 1, ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (4) @(negedge Clk);
    check("sb_drained", sb_q.size(), 0);
    check("final_count", RetireCount, ref_count);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
